digit_serializer: RTL
=====================

Name: digit_serializer

Overview:
- Converts a binary result word from the day-3 bank solver (`aoc_day3`, 41-bit `result_out`) back into a stream of decimal digits.
- Digits come out one per handshake, most significant first; the stream is the inverse of the solver's `digit_in` feed.
- Sits downstream of the solver and feeds the display/UART path or a bench scoreboard that compares digit streams.
- Conversion is iterative double-dabble, followed by a leading-zero skip and a valid/ready output stream.

Parameters:
- VAL_W, 41, width of the binary input value.
- NUM_DIGITS, 13, number of BCD nibbles held internally; must satisfy 10^NUM_DIGITS > 2^VAL_W - 1.
- SUPPRESS_ZEROS, 1, 1 = skip leading zeros; 0 = always emit all NUM_DIGITS digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  value_in is offered.
- in_ready  output  1  block can accept a new value.
- value_in  input  VAL_W  unsigned binary value to convert.
- digit_out  output  4  current decimal digit, 0-9.
- digit_valid  output  1  digit_out is valid.
- digit_ready  input  1  consumer accepts digit_out this cycle.
- digit_last  output  1  digit_out is the least significant digit of the number.
- busy  output  1  high in CONVERT or EMIT.

Behaviour:
- Reset, synchronous on a rising clk edge with rst=1:
  - state=IDLE; in_ready=0 while rst=1.
  - digit_valid=0, digit_last=0, digit_out=0, busy=0; BCD register and counters cleared.
  - in_ready=1 in the first cycle after rst falls.
  - Reset has priority over everything, including mid-CONVERT and mid-EMIT. A partial number is dropped with no further digit_valid.
- State machine: IDLE -> CONVERT -> EMIT -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch value_in into the shift register, clear the BCD register, set iter=VAL_W, go to CONVERT.
  - value_in is sampled only on the accepting edge.
- CONVERT:
  - in_ready=0, busy=1.
  - Each cycle: every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1 and iter decrements.
  - After exactly VAL_W iterations, go to EMIT.
  - On that transition, idx = index of the highest nonzero nibble, or 0 if all nibbles are zero. When SUPPRESS_ZEROS=0, idx = NUM_DIGITS-1.
- Latency: digit_valid first rises exactly VAL_W+1 rising edges after the accepting edge. For VAL_W=41, that is 42 edges.
- EMIT:
  - digit_valid=1, digit_out=bcd[idx], digit_last=(idx==0), busy=1, in_ready=0.
  - On digit_ready: if idx==0, go to IDLE; otherwise idx decrements.
  - digit_out and digit_last hold stable while digit_valid=1 && digit_ready=0 (no change under backpressure).
  - With digit_ready held high, one digit transfers per cycle.
- Zero value: emits exactly one digit 0 with digit_last=1, regardless of SUPPRESS_ZEROS=1.
- Internal zeros (after the first nonzero digit) are always emitted.
- No input overlap: a new value is not accepted before the last digit transfers. in_ready returns to 1 the cycle after the last-digit handshake.
- Arithmetic:
  - Each nibble is 4 bits; +3 never overflows a nibble.
  - Values up to 2^VAL_W - 1 are represented exactly.
  - Nibbles never hold values above 9 after CONVERT completes.

Test Plan:
- Reset, then value_in=98654 offered with digit_ready=1 -> accept on the first IDLE cycle; first digit_valid 42 edges later; stream 9,8,6,5,4 on consecutive cycles; digit_last only on 4; in_ready=1 the next cycle.
- value_in=0 -> exactly one transfer, digit_out=0, digit_last=1; with SUPPRESS_ZEROS=0, thirteen 0 digits are emitted instead.
- value_in=2^41-1 -> stream 2,1,9,9,0,2,3,2,5,5,5,5,1 (13 digits), with digit_last on the final 1.
- value_in=1000000000000 -> 1 followed by twelve 0 digits, all emitted; digit_last on the 13th digit.
- value_in=98654 with digit_ready toggled 1,0,0,1,0,1,1,... -> digit_out holds stable during stalls; the received sequence is still 9,8,6,5,4; in_valid is ignored while busy=1.
- rst pulsed high for 1 cycle after two digits of 98654 have transferred -> digit_valid=0 and busy=0 the next cycle; in_ready=1 after rst falls; a following value 7 yields the single digit 7 with digit_last=1.

Source files
------------

// File: rtl/digit_serializer.sv
// ---------------------------------------------------------------------------
// digit_serializer : binary word -> MSD-first decimal digit stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module digit_serializer #(
  parameter int VAL_W          = 41,
  parameter int NUM_DIGITS     = 13,
  parameter bit SUPPRESS_ZEROS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] value_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  input  logic             digit_ready,
  output logic             digit_last,
  output logic             busy
);

  localparam int BCD_W  = 4 * NUM_DIGITS;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int ITER_W = $clog2(VAL_W + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t            state;
  logic [VAL_W-1:0]  bin;
  logic [BCD_W-1:0]  bcd;
  logic [BCD_W-1:0]  bcd_adj;
  logic [ITER_W-1:0] iter;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  top_idx;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Highest nonzero nibble wins; an all-zero value still yields nibble 0.
  always_comb begin
    top_idx = '0;
    if (!SUPPRESS_ZEROS) begin
      top_idx = IDX_W'(NUM_DIGITS - 1);
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bcd[4*i +: 4] != 4'd0) top_idx = IDX_W'(i);
      end
    end
  end

  function automatic logic [3:0] nib(input logic [BCD_W-1:0] b, input logic [IDX_W-1:0] k);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (k == IDX_W'(i)) r = b[4*i +: 4];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bin         <= '0;
      bcd         <= '0;
      iter        <= '0;
      idx         <= '0;
      digit_out   <= 4'd0;
      digit_valid <= 1'b0;
      digit_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin   <= value_in;
            bcd   <= '0;
            iter  <= ITER_W'(VAL_W);
            state <= CONVERT;
          end
        end
        CONVERT: begin
          // The iter==0 cycle picks the first digit from the settled BCD word.
          if (iter != '0) begin
            bcd  <= {bcd_adj[BCD_W-2:0], bin[VAL_W-1]};
            bin  <= {bin[VAL_W-2:0], 1'b0};
            iter <= iter - 1'b1;
          end else begin
            idx         <= top_idx;
            digit_out   <= nib(bcd, top_idx);
            digit_last  <= (top_idx == '0);
            digit_valid <= 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (digit_ready) begin
            if (idx == '0) begin
              digit_valid <= 1'b0;
              digit_last  <= 1'b0;
              digit_out   <= 4'd0;
              state       <= IDLE;
            end else begin
              idx        <= idx - 1'b1;
              digit_out  <= nib(bcd, idx - 1'b1);
              digit_last <= (idx == IDX_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

endmodule

`default_nettype wire
